// File: rtl/draw_circles_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | draw_circles_multi_pkg : shared sizes, VGA timing constants, helper funcs   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package draw_circles_multi_pkg;

  localparam int C_N_OBJ    = 3;
  localparam int C_COORD_W  = 12;
  localparam int C_RADIUS_W = 8;
  localparam int C_RGB_W    = 12;
  localparam int C_LAT      = 3;
  localparam logic [C_RGB_W-1:0] C_BLANK_RGB = 12'h000;

  // 1024x768 @ 60 Hz timing, shared with the timing generator
  localparam int C_H_ACTIVE = 1024;
  localparam int C_H_TOTAL  = 1344;
  localparam int C_V_ACTIVE = 768;
  localparam int C_V_TOTAL  = 806;

  // Squared distance width: two (COORD_W+1)-bit squares plus one carry bit
  function automatic int d2_width(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/draw_circles_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | draw_circles_multi_if : video stream in/out plus per-frame object bus      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface draw_circles_multi_if #(
  parameter int N_OBJ    = 3,
  parameter int COORD_W  = 12,
  parameter int RADIUS_W = 8,
  parameter int RGB_W    = 12
);
  logic [COORD_W-1:0]        hcount_in;
  logic [COORD_W-1:0]        vcount_in;
  logic                      hsync_in;
  logic                      vsync_in;
  logic                      hblnk_in;
  logic                      vblnk_in;
  logic [RGB_W-1:0]          rgb_in;
  logic [N_OBJ*COORD_W-1:0]  xpos_in;
  logic [N_OBJ*COORD_W-1:0]  ypos_in;
  logic [N_OBJ*RADIUS_W-1:0] radius_in;
  logic [N_OBJ*RGB_W-1:0]    color_in;
  logic [N_OBJ-1:0]          enable_in;

  logic [COORD_W-1:0]        hcount_out;
  logic [COORD_W-1:0]        vcount_out;
  logic                      hsync_out;
  logic                      vsync_out;
  logic                      hblnk_out;
  logic                      vblnk_out;
  logic [RGB_W-1:0]          rgb_out;
  logic [N_OBJ-1:0]          hit_mask_out;
  logic                      frame_latch;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output xpos_in, ypos_in, radius_in, color_in, enable_in,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    input  rgb_out, hit_mask_out, frame_latch
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  xpos_in, ypos_in, radius_in, color_in, enable_in,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    output rgb_out, hit_mask_out, frame_latch
  );
endinterface
`default_nettype wire

// File: rtl/draw_circles_multi_circle_hit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | draw_circles_multi_circle_hit : two-stage distance pipe + inside compare   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module draw_circles_multi_circle_hit
  import draw_circles_multi_pkg::*;
#(
  parameter int COORD_W  = C_COORD_W,
  parameter int RADIUS_W = C_RADIUS_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [COORD_W-1:0]  hcount_i,
  input  logic [COORD_W-1:0]  vcount_i,
  input  logic [COORD_W-1:0]  x_i,
  input  logic [COORD_W-1:0]  y_i,
  input  logic [RADIUS_W-1:0] r_i,
  input  logic                en_i,
  output logic                inside_o
);
  localparam int D2_W = d2_width(COORD_W);

  logic signed [COORD_W:0] dx_d, dy_d, dx_q, dy_q;
  logic [RADIUS_W-1:0]     r_q;
  logic                    en_s1_q;
  logic [COORD_W:0]        adx_w, ady_w;
  logic [D2_W-1:0]         adx_e, ady_e, r_e;
  logic [D2_W-1:0]         d2_d, r2_d, d2_q, r2_q;
  logic                    en_s2_q;

  // Signed differences keep edge-clipped circles correct without wrap-around
  assign dx_d = $signed({1'b0, hcount_i}) - $signed({1'b0, x_i});
  assign dy_d = $signed({1'b0, vcount_i}) - $signed({1'b0, y_i});

  assign adx_w = dx_q[COORD_W] ? $unsigned(-dx_q) : $unsigned(dx_q);
  assign ady_w = dy_q[COORD_W] ? $unsigned(-dy_q) : $unsigned(dy_q);
  assign adx_e = D2_W'(adx_w);
  assign ady_e = D2_W'(ady_w);
  assign r_e   = D2_W'(r_q);
  assign d2_d  = adx_e * adx_e + ady_e * ady_e;
  assign r2_d  = r_e * r_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q    <= '0;
      dy_q    <= '0;
      r_q     <= '0;
      en_s1_q <= 1'b0;
      d2_q    <= '0;
      r2_q    <= '0;
      en_s2_q <= 1'b0;
    end else begin
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      r_q     <= r_i;
      en_s1_q <= en_i;
      d2_q    <= d2_d;
      r2_q    <= r2_d;
      en_s2_q <= en_s1_q;
    end
  end

  assign inside_o = en_s2_q & (d2_q <= r2_q);

endmodule
`default_nettype wire

// File: rtl/draw_circles_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | draw_circles_multi : N filled circles composited over video, 3-cycle pipe  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module draw_circles_multi
  import draw_circles_multi_pkg::*;
#(
  parameter int N_OBJ    = C_N_OBJ,
  parameter int COORD_W  = C_COORD_W,
  parameter int RADIUS_W = C_RADIUS_W,
  parameter int RGB_W    = C_RGB_W,
  parameter logic [RGB_W-1:0] BLANK_RGB = RGB_W'(C_BLANK_RGB)
) (
  input  logic               clk,
  input  logic               rst_n,
  draw_circles_multi_if.slave bus
);
  localparam int LAT    = C_LAT;
  localparam int TW     = 2 * COORD_W + 4 + RGB_W;
  localparam int VB_B   = RGB_W;
  localparam int HB_B   = RGB_W + 1;
  localparam int VS_B   = RGB_W + 2;
  localparam int HS_B   = RGB_W + 3;
  localparam int VC_LSB = RGB_W + 4;
  localparam int HC_LSB = RGB_W + 4 + COORD_W;

  logic                      vblnk_prev_q;
  logic                      frame_latch_q;
  logic                      vblnk_rise_w;
  logic [N_OBJ*COORD_W-1:0]  x_sh_q, y_sh_q;
  logic [N_OBJ*RADIUS_W-1:0] r_sh_q;
  logic [N_OBJ*RGB_W-1:0]    col_sh_q, col_s1_q, col_s2_q;
  logic [N_OBJ-1:0]          en_sh_q;
  logic [TW-1:0]             tpipe_q [LAT];
  logic [N_OBJ-1:0]          inside_w;
  logic [RGB_W-1:0]          rgb_d, rgb_q;
  logic [N_OBJ-1:0]          hit_d, hit_q;

  assign vblnk_rise_w = bus.vblnk_in & ~vblnk_prev_q;

  // Shadow copy is taken only on blanking entry so a frame never sees a mix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q  <= 1'b0;
      frame_latch_q <= 1'b0;
      x_sh_q        <= '0;
      y_sh_q        <= '0;
      r_sh_q        <= '0;
      col_sh_q      <= '0;
      en_sh_q       <= '0;
    end else begin
      vblnk_prev_q  <= bus.vblnk_in;
      frame_latch_q <= vblnk_rise_w;
      if (vblnk_rise_w) begin
        x_sh_q   <= bus.xpos_in;
        y_sh_q   <= bus.ypos_in;
        r_sh_q   <= bus.radius_in;
        col_sh_q <= bus.color_in;
        en_sh_q  <= bus.enable_in;
      end
    end
  end

  for (genvar k = 0; k < N_OBJ; k++) begin : g_obj
    draw_circles_multi_circle_hit #(
      .COORD_W  (COORD_W),
      .RADIUS_W (RADIUS_W)
    ) u_hit (
      .clk      (clk),
      .rst_n    (rst_n),
      .hcount_i (bus.hcount_in),
      .vcount_i (bus.vcount_in),
      .x_i      (x_sh_q[k*COORD_W +: COORD_W]),
      .y_i      (y_sh_q[k*COORD_W +: COORD_W]),
      .r_i      (r_sh_q[k*RADIUS_W +: RADIUS_W]),
      .en_i     (en_sh_q[k]),
      .inside_o (inside_w[k])
    );
  end

  // Colours ride along with the geometry so in-flight pixels keep their frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
      for (int i = 0; i < LAT; i++) tpipe_q[i] <= '0;
      rgb_q    <= '0;
      hit_q    <= '0;
    end else begin
      col_s1_q   <= col_sh_q;
      col_s2_q   <= col_s1_q;
      tpipe_q[0] <= {bus.hcount_in, bus.vcount_in, bus.hsync_in, bus.vsync_in,
                     bus.hblnk_in, bus.vblnk_in, bus.rgb_in};
      for (int i = 1; i < LAT; i++) tpipe_q[i] <= tpipe_q[i-1];
      rgb_q      <= rgb_d;
      hit_q      <= hit_d;
    end
  end

  always_comb begin
    rgb_d = tpipe_q[LAT-2][RGB_W-1:0];
    hit_d = inside_w;
    for (int k = N_OBJ - 1; k >= 0; k--) begin
      if (inside_w[k]) rgb_d = col_s2_q[k*RGB_W +: RGB_W];
    end
    if (tpipe_q[LAT-2][HB_B] || tpipe_q[LAT-2][VB_B]) begin
      rgb_d = BLANK_RGB;
      hit_d = '0;
    end
  end

  assign bus.hcount_out   = tpipe_q[LAT-1][HC_LSB +: COORD_W];
  assign bus.vcount_out   = tpipe_q[LAT-1][VC_LSB +: COORD_W];
  assign bus.hsync_out    = tpipe_q[LAT-1][HS_B];
  assign bus.vsync_out    = tpipe_q[LAT-1][VS_B];
  assign bus.hblnk_out    = tpipe_q[LAT-1][HB_B];
  assign bus.vblnk_out    = tpipe_q[LAT-1][VB_B];
  assign bus.rgb_out      = rgb_q;
  assign bus.hit_mask_out = hit_q;
  assign bus.frame_latch  = frame_latch_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_circles_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_draw_circles_multi : directed self-checking bench for draw_circles_multi|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_draw_circles_multi;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  draw_circles_multi_if #(.N_OBJ(3), .COORD_W(12), .RADIUS_W(8), .RGB_W(12)) bus ();

  draw_circles_multi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int k, input int x, input int y, input int r,
                         input logic [11:0] c, input logic en);
    bus.xpos_in[k*12 +: 12]  = 12'(x);
    bus.ypos_in[k*12 +: 12]  = 12'(y);
    bus.radius_in[k*8 +: 8]  = 8'(r);
    bus.color_in[k*12 +: 12] = c;
    bus.enable_in[k]         = en;
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] rgb);
    bus.hcount_in = 12'(h);
    bus.vcount_in = 12'(v);
    bus.rgb_in    = rgb;
    bus.hblnk_in  = 1'b0;
    bus.vblnk_in  = 1'b0;
  endtask

  // Pixel held for the full pipeline depth, then output compared
  task automatic pchk(input string tag, input int h, input int v, input logic [11:0] bg,
                      input logic [11:0] exp_rgb, input logic [2:0] exp_hit);
    pix(h, v, bg);
    ticks(3);
    chk({tag, "_rgb"}, 32'(bus.rgb_out), 32'(exp_rgb));
    chk({tag, "_hit"}, 32'(bus.hit_mask_out), 32'(exp_hit));
  endtask

  task automatic latch(input string tag);
    bus.vblnk_in = 1'b0;
    tick();
    bus.vblnk_in = 1'b1;
    tick();
    chk({tag, "_fl_pulse"}, 32'(bus.frame_latch), 32'd1);
    tick();
    chk({tag, "_fl_once"}, 32'(bus.frame_latch), 32'd0);
    bus.vblnk_in = 1'b0;
    tick();
  endtask

  initial begin
    bus.hcount_in = 12'd500;
    bus.vcount_in = 12'd40;
    bus.hsync_in  = 1'b1;
    bus.vsync_in  = 1'b0;
    bus.hblnk_in  = 1'b0;
    bus.vblnk_in  = 1'b0;
    bus.rgb_in    = 12'hFFF;
    bus.xpos_in   = '0;
    bus.ypos_in   = '0;
    bus.radius_in = '0;
    bus.color_in  = '0;
    bus.enable_in = '0;

    // Reset held with live inputs
    ticks(3);
    bus.vblnk_in = 1'b1;
    tick();
    chk("rst_rgb", 32'(bus.rgb_out), 32'h0);
    chk("rst_hit", 32'(bus.hit_mask_out), 32'h0);
    chk("rst_fl", 32'(bus.frame_latch), 32'h0);
    chk("rst_hcount", 32'(bus.hcount_out), 32'h0);
    chk("rst_hsync", 32'(bus.hsync_out), 32'h0);

    // Release mid-line: object inputs set but not yet latched
    bus.hsync_in = 1'b0;
    set_obj(0, 100, 100, 10, 12'hF00, 1'b1);
    pix(100, 100, 12'h000);
    rst_n = 1'b1;
    ticks(4);
    chk("prelatch_rgb", 32'(bus.rgb_out), 32'h0);
    chk("prelatch_hit", 32'(bus.hit_mask_out), 32'h0);
    chk("prelatch_fl", 32'(bus.frame_latch), 32'h0);

    // Single circle, exact latency
    latch("l1");
    pix(110, 100, 12'h123);
    bus.hsync_in = 1'b1;
    tick();
    pix(111, 100, 12'h123);
    bus.hsync_in = 1'b0;
    ticks(2);
    chk("lat_edge_rgb", 32'(bus.rgb_out), 32'hF00);
    chk("lat_edge_hit", 32'(bus.hit_mask_out), 32'h1);
    chk("lat_hcount", 32'(bus.hcount_out), 32'd110);
    chk("lat_hsync", 32'(bus.hsync_out), 32'd1);
    tick();
    chk("outside_rgb", 32'(bus.rgb_out), 32'h123);
    chk("outside_hit", 32'(bus.hit_mask_out), 32'h0);
    chk("outside_hcount", 32'(bus.hcount_out), 32'd111);
    pchk("centre", 100, 100, 12'h123, 12'hF00, 3'b001);

    // Overlap and priority
    set_obj(0, 200, 200, 20, 12'hF00, 1'b1);
    set_obj(1, 210, 200, 20, 12'h00F, 1'b1);
    latch("l2");
    pchk("ovl_both", 215, 200, 12'h0A0, 12'hF00, 3'b011);
    pchk("ovl_obj1", 225, 200, 12'h0A0, 12'h00F, 3'b010);
    pchk("ovl_bound", 200, 220, 12'h0A0, 12'hF00, 3'b001);
    pchk("ovl_none", 200, 221, 12'h0A0, 12'h0A0, 3'b000);

    // Mid-frame input change stays hidden until the next latch
    pix(215, 300, 12'h0A0);
    set_obj(0, 600, 200, 20, 12'hF00, 1'b1);
    tick();
    pchk("midframe", 215, 200, 12'h0A0, 12'hF00, 3'b011);
    chk("midframe_fl", 32'(bus.frame_latch), 32'h0);
    latch("l3");
    pchk("newframe_old", 215, 200, 12'h0A0, 12'h00F, 3'b010);
    pchk("newframe_new", 600, 200, 12'h0A0, 12'hF00, 3'b001);

    // Corner circle clipped at the screen edge
    set_obj(0, 0, 0, 15, 12'hF00, 1'b1);
    set_obj(1, 210, 200, 20, 12'h00F, 1'b0);
    latch("l4");
    pchk("corner_c", 0, 0, 12'h055, 12'hF00, 3'b001);
    pchk("corner_in", 10, 10, 12'h055, 12'hF00, 3'b001);
    pchk("corner_out", 11, 11, 12'h055, 12'h055, 3'b000);
    pchk("corner_edge", 0, 15, 12'h055, 12'hF00, 3'b001);
    pchk("corner_wrap", 1023, 0, 12'h055, 12'h055, 3'b000);

    // Blanking inside a circle
    pix(0, 0, 12'h055);
    bus.hblnk_in = 1'b1;
    ticks(3);
    chk("hblnk_rgb", 32'(bus.rgb_out), 32'h0);
    chk("hblnk_hit", 32'(bus.hit_mask_out), 32'h0);
    chk("hblnk_out", 32'(bus.hblnk_out), 32'h1);

    // All disabled: straight pass-through delayed by three
    bus.enable_in = 3'b000;
    latch("l5");
    pix(0, 0, 12'hA11);
    tick();
    pix(0, 0, 12'hB22);
    tick();
    pix(0, 0, 12'hC33);
    tick();
    chk("pass0", 32'(bus.rgb_out), 32'hA11);
    tick();
    chk("pass1", 32'(bus.rgb_out), 32'hB22);
    chk("pass_hit", 32'(bus.hit_mask_out), 32'h0);

    // Mid-frame reset clears immediately and stays clear until a latch
    bus.enable_in = 3'b001;
    latch("l6");
    pchk("pre_rst", 0, 0, 12'h5A5, 12'hF00, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rgb", 32'(bus.rgb_out), 32'h0);
    chk("async_hit", 32'(bus.hit_mask_out), 32'h0);
    tick();
    rst_n = 1'b1;
    pchk("post_rst", 0, 0, 12'h5A5, 12'h5A5, 3'b000);
    latch("l7");
    pchk("resume", 0, 0, 12'h5A5, 12'hF00, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
